// File: rtl/alu_wide_pkg.sv
// Shared definitions for the multi-cycle wide ALU.
// Contents:
//   wide_alu_op_e : 3-bit operation encoding (WADD, WADC, WSBC, WINC, WDEC; 5..7 undefined)
//   state_e       : sequencer states (StIdle, StRun, StDone)
//   FLAG_*        : bit positions within the Z80 F register
//   helper functions for opcode decoding and carry-in selection
package alu_wide_pkg;

    typedef enum logic [2:0] {
        WADD = 3'd0,
        WADC = 3'd1,
        WSBC = 3'd2,
        WINC = 3'd3,
        WDEC = 3'd4
    } wide_alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned FLAG_S  = 7;
    localparam int unsigned FLAG_Z  = 6;
    localparam int unsigned FLAG_Y  = 5;
    localparam int unsigned FLAG_H  = 4;
    localparam int unsigned FLAG_X  = 3;
    localparam int unsigned FLAG_PV = 2;
    localparam int unsigned FLAG_N  = 1;
    localparam int unsigned FLAG_C  = 0;

    // True for the five defined encodings.
    function automatic logic op_is_defined(logic [2:0] op);
        return (op <= 3'd4);
    endfunction

    // Initial carry (add) or borrow (subtract) entering the low byte.
    function automatic logic initial_carry(logic [2:0] op, logic flag_c);
        logic c;
        case (op)
            WADC, WSBC: c = flag_c;
            WINC, WDEC: c = 1'b1;
            default:    c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_byte_slice.sv
// One byte of the wide adder/subtractor (purely combinational).
// Ports:
//   a_i, b_i  : operand bytes
//   carry_i   : carry-in (add) or borrow-in (subtract)
//   sub_i     : 1 = a - b - borrow, 0 = a + b + carry
//   sum_o     : result byte
//   carry_o   : carry-out (add) or borrow-out (subtract) of bit 7
//   half_o    : carry/borrow out of bit 3
//   ovf_o     : two's-complement overflow of this byte
module alu_byte_slice (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       carry_i,
    input  logic       sub_i,
    output logic [7:0] sum_o,
    output logic       carry_o,
    output logic       half_o,
    output logic       ovf_o
);

    logic [8:0] full;
    logic [4:0] nib;

    always_comb begin
        if (sub_i) begin
            // 9-bit wrap makes bit 8 / bit 4 the borrow out.
            full  = {1'b0, a_i} - {1'b0, b_i} - {8'd0, carry_i};
            nib   = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - {4'd0, carry_i};
            ovf_o = (a_i[7] ^ b_i[7]) & (full[7] ^ a_i[7]);
        end else begin
            full  = {1'b0, a_i} + {1'b0, b_i} + {8'd0, carry_i};
            nib   = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'd0, carry_i};
            ovf_o = ~(a_i[7] ^ b_i[7]) & (full[7] ^ a_i[7]);
        end
        sum_o   = full[7:0];
        carry_o = full[8];
        half_o  = nib[4];
    end

endmodule

// File: rtl/alu_wide_seq.sv
// Multi-cycle Z80 wide arithmetic unit (ADD/ADC/SBC/INC/DEC), one byte per clock, LSB first.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (in_ready high only while idle)
//   opcode, a, b         : operation and operands, latched on the accept edge
//   flags_in             : current F; carry-in source and preserved bits
//   out_valid / out_ready: result handshake
//   result, flags_out    : registered result and new F image
module alu_wide_seq
    import alu_wide_pkg::*;
#(
    parameter int unsigned NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            opcode,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic [7:0]            flags_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   result,
    output logic [7:0]            flags_out
);

    localparam int unsigned WIDTH = 8 * NBYTES;
    localparam int unsigned IdxW  = (NBYTES > 2) ? 2 : 1;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic [7:0]        fin_q;
    logic [7:0]        fout_q;
    logic              carry_q;
    logic              zacc_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [7:0] slice_b;
    logic       slice_sub;
    logic [7:0] slice_sum;
    logic       slice_carry;
    logic       slice_half;
    logic       slice_ovf;
    logic [7:0] res_byte;
    logic       byte_zero;
    logic       last_byte;
    logic [7:0] flags_d;

    // Operands shift right one byte per cycle, so the slice always sees byte 0.
    always_comb begin
        slice_b   = ((op_q == WINC) || (op_q == WDEC)) ? 8'h00 : b_q[7:0];
        slice_sub = (op_q == WSBC) || (op_q == WDEC);
        res_byte  = op_is_defined(op_q) ? slice_sum : a_q[7:0];
        byte_zero = (res_byte == 8'h00);
        last_byte = (idx_q == IdxW'(NBYTES - 1));
    end

    alu_byte_slice u_slice (
        .a_i     (a_q[7:0]),
        .b_i     (slice_b),
        .carry_i (carry_q),
        .sub_i   (slice_sub),
        .sum_o   (slice_sum),
        .carry_o (slice_carry),
        .half_o  (slice_half),
        .ovf_o   (slice_ovf)
    );

    // Flag image built from the top-byte slice outputs; only used on the last byte.
    always_comb begin
        flags_d = fin_q;
        case (op_q)
            WADD: begin
                flags_d[FLAG_Y] = slice_sum[5];
                flags_d[FLAG_H] = slice_half;
                flags_d[FLAG_X] = slice_sum[3];
                flags_d[FLAG_N] = 1'b0;
                flags_d[FLAG_C] = slice_carry;
            end
            WADC, WSBC: begin
                flags_d[FLAG_S]  = slice_sum[7];
                flags_d[FLAG_Z]  = zacc_q & byte_zero;
                flags_d[FLAG_Y]  = slice_sum[5];
                flags_d[FLAG_H]  = slice_half;
                flags_d[FLAG_X]  = slice_sum[3];
                flags_d[FLAG_PV] = slice_ovf;
                flags_d[FLAG_N]  = (op_q == WSBC);
                flags_d[FLAG_C]  = slice_carry;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            op_q        <= 3'd0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            fin_q       <= 8'h00;
            fout_q      <= 8'h00;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q       <= opcode;
                        a_q        <= a;
                        b_q        <= b;
                        fin_q      <= flags_in;
                        carry_q    <= initial_carry(opcode, flags_in[FLAG_C]);
                        idx_q      <= '0;
                        zacc_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    carry_q <= slice_carry;
                    zacc_q  <= zacc_q & byte_zero;
                    // New byte enters at the top; after NBYTES shifts it sits in place.
                    res_q   <= {res_byte, res_q[WIDTH-1:8]};
                    a_q     <= a_q >> 8;
                    b_q     <= b_q >> 8;
                    idx_q   <= idx_q + 1'b1;
                    if (last_byte) begin
                        fout_q      <= flags_d;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign flags_out = fout_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq: a 2-byte instance for most vectors and a 3-byte instance
// for the wider carry chain.
module tb_alu_wide_seq;

    logic        clk;
    logic        reset;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  flags_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [7:0]  flags_out;

    logic        in_valid3;
    logic        in_ready3;
    logic [2:0]  opcode3;
    logic [23:0] a3;
    logic [23:0] b3;
    logic [7:0]  flags_in3;
    logic        out_valid3;
    logic        out_ready3;
    logic [23:0] result3;
    logic [7:0]  flags_out3;

    int n_checks;
    int n_pass;

    alu_wide_seq #(.NBYTES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .flags_in  (flags_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags_out (flags_out)
    );

    alu_wide_seq #(.NBYTES(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .opcode    (opcode3),
        .a         (a3),
        .b         (b3),
        .flags_in  (flags_in3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .result    (result3),
        .flags_out (flags_out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept edge, then count cycles until out_valid (bounded).
    task automatic issue2(input logic [2:0] op, input logic [15:0] ta, input logic [15:0] tb,
                          input logic [7:0] tf, output int lat);
        opcode   = op;
        a        = ta;
        b        = tb;
        flags_in = tf;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs to show they were latched.
        opcode   = 3'd7;
        a        = ~ta;
        b        = ~tb;
        flags_in = ~tf;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release2(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'h2);
    endtask

    task automatic run2(input string tag, input logic [2:0] op, input logic [15:0] ta,
                        input logic [15:0] tb, input logic [7:0] tf,
                        input logic [15:0] exp_r, input logic [7:0] exp_f);
        int lat;
        check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        issue2(op, ta, tb, tf, lat);
        check_eq({tag, "_lat"}, lat, 32'd2);
        check_eq({tag, "_res"}, {16'd0, result}, {16'd0, exp_r});
        check_eq({tag, "_flg"}, {24'd0, flags_out}, {24'd0, exp_f});
        release2(tag);
    endtask

    initial begin
        int lat;
        logic [15:0] held_r;
        logic [7:0]  held_f;

        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        opcode     = 3'd0;
        a          = '0;
        b          = '0;
        flags_in   = 8'h00;
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;
        opcode3    = 3'd0;
        a3         = '0;
        b3         = '0;
        flags_in3  = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check_eq("rst_ready",  {31'd0, in_ready},  32'd1);
        check_eq("rst_valid",  {31'd0, out_valid}, 32'd0);
        check_eq("rst_result", {16'd0, result},    32'd0);
        check_eq("rst_flags",  {24'd0, flags_out}, 32'd0);

        // S, Z, P/V kept from flags_in; H from 0xF+carry in the top nibble.
        run2("wadd",    3'd0, 16'h0FFF, 16'h0001, 8'hFF, 16'h1000, 8'hD4);
        run2("wadc",    3'd1, 16'h7FFF, 16'h0000, 8'h01, 16'h8000, 8'h94);
        run2("wsbc_ff", 3'd2, 16'h0000, 16'h0000, 8'h01, 16'hFFFF, 8'hBB);
        run2("wsbc_z",  3'd2, 16'h1234, 16'h1234, 8'h00, 16'h0000, 8'h42);
        // Low byte zero only: Z stays clear, N set by the subtract.
        run2("wsbc_lo", 3'd2, 16'h0100, 16'h0000, 8'h00, 16'h0100, 8'h02);
        run2("winc",    3'd3, 16'hFFFF, 16'h1234, 8'h00, 16'h0000, 8'h00);
        run2("wdec",    3'd4, 16'h0000, 16'h5555, 8'h5A, 16'hFFFF, 8'h5A);
        run2("undef",   3'd6, 16'hBEEF, 16'h1111, 8'hA5, 16'hBEEF, 8'hA5);

        // Backpressure: hold DONE for 5 cycles while in_valid pulses.
        issue2(3'd0, 16'h1234, 16'h1111, 8'h00, lat);
        check_eq("bp_lat", lat, 32'd2);
        held_r = result;
        held_f = flags_out;
        check_eq("bp_res", {16'd0, held_r}, 32'h2345);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            opcode   = 3'd1;
            a        = 16'hFFFF;
            b        = 16'hFFFF;
            @(posedge clk);
            #1;
            check_eq("bp_hold_res", {16'd0, result}, {16'd0, held_r});
            check_eq("bp_hold_flg", {24'd0, flags_out}, {24'd0, held_f});
            check_eq("bp_hold_hs",  {30'd0, in_ready, out_valid}, 32'h1);
        end
        in_valid = 1'b0;

        // out_ready and in_valid together in DONE: not accepted until IDLE.
        opcode    = 3'd0;
        a         = 16'h0001;
        b         = 16'h0001;
        flags_in  = 8'h00;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("ovl_idle", {30'd0, in_ready, out_valid}, 32'h2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("ovl_acc", {30'd0, in_ready, out_valid}, 32'h0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("ovl_lat", lat, 32'd2);
        check_eq("ovl_res", {16'd0, result}, 32'h0002);
        release2("ovl");

        // Reset while processing byte index 1.
        opcode   = 3'd0;
        a        = 16'h1111;
        b        = 16'h2222;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("mrst_hs",  {30'd0, in_ready, out_valid}, 32'h2);
        check_eq("mrst_res", {16'd0, result}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("mrst_quiet", {31'd0, out_valid}, 32'd0);

        // Three-byte carry chain.
        check_eq("n3_rdy", {31'd0, in_ready3}, 32'd1);
        opcode3   = 3'd0;
        a3        = 24'hFFFFFF;
        b3        = 24'h000001;
        flags_in3 = 8'h00;
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        a3        = 24'h0;
        lat = 0;
        while (!out_valid3 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("n3_lat", lat, 32'd3);
        check_eq("n3_res", {8'd0, result3}, 32'd0);
        check_eq("n3_flg", {24'd0, flags_out3}, 32'h11);
        out_ready3 = 1'b1;
        @(posedge clk);
        #1;
        out_ready3 = 1'b0;
        check_eq("n3_idle", {30'd0, in_ready3, out_valid3}, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
